monitor_loader: RTL and testbench

- Boot-time Wishbone copy engine that sits directly upstream of the monitor RAM.
- Fetches WORDS 32-bit words from a source slave (boot flash) over one Wishbone master port and writes them into the monitor RAM over a second master port.
- Drives the monitor's write_lock: the lock is released only while the image is being loaded and is reasserted once the copy ends.
- Holds the CPU in reset until the copy completes successfully.

---
 rtl/monitor_loader.sv | 117 +++++++++++
 tb/tb_monitor_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_loader.sv
// rtl/monitor_loader.sv - boot-time Wishbone copy engine filling the monitor RAM from boot flash
module monitor_loader #(
    parameter logic [31:0] SRC_BASE = 32'h0000_0000,
    parameter logic [31:0] DST_BASE = 32'h0000_0000,
    parameter int          WORDS    = 512,
    parameter int          TIMEOUT  = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic [31:0] src_adr_o,
    input  logic [31:0] src_dat_i,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    input  logic        src_ack_i,
    output logic [31:0] dst_adr_o,
    output logic [31:0] dst_dat_o,
    output logic [3:0]  dst_sel_o,
    output logic        dst_cyc_o,
    output logic        dst_stb_o,
    output logic        dst_we_o,
    input  logic        dst_ack_i,
    output logic        write_lock,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CW = $clog2(WORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [15:0]   tcnt;
    logic [31:0]   data_q;
    logic          last_word;
    logic          timed_out;

    assign last_word = (cnt == CW'(WORDS - 1));
    assign timed_out = (tcnt == 16'(TIMEOUT));

    // An ack in the same cycle as the timeout wins over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_next = S_READ;
            end
            S_READ: begin
                if (src_ack_i)      state_next = S_WRITE;
                else if (timed_out) state_next = S_ERROR;
            end
            S_WRITE: begin
                if (dst_ack_i)      state_next = last_word ? S_DONE : S_READ;
                else if (timed_out) state_next = S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_next;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt    <= '0;
            tcnt   <= '0;
            data_q <= '0;
        end else begin
            if (state_next != state)
                tcnt <= '0;
            else if (state == S_READ || state == S_WRITE)
                tcnt <= tcnt + 16'd1;

            // The word counter is left untouched in ERROR so the failing index stays visible.
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) cnt <= '0;
                end
                S_READ: begin
                    if (src_ack_i) data_q <= src_dat_i;
                end
                S_WRITE: begin
                    if (dst_ack_i && !last_word) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign src_adr_o  = SRC_BASE + (32'(cnt) << 2);
    assign dst_adr_o  = DST_BASE + (32'(cnt) << 2);
    assign dst_dat_o  = data_q;
    assign dst_sel_o  = 4'hF;
    assign src_cyc_o  = (state == S_READ);
    assign src_stb_o  = (state == S_READ);
    assign dst_cyc_o  = (state == S_WRITE);
    assign dst_stb_o  = (state == S_WRITE);
    assign dst_we_o   = (state == S_WRITE);
    assign busy       = (state == S_READ) || (state == S_WRITE);
    assign write_lock = !busy;
    assign cpu_rst    = (state != S_DONE);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);

endmodule

// File: tb/tb_monitor_loader.sv
// tb/tb_monitor_loader.sv - directed self-checking bench for monitor_loader
module tb_monitor_loader;

    localparam logic [31:0] SRC_BASE = 32'hFFFF_FFF8;
    localparam logic [31:0] DST_BASE = 32'h0002_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [31:0] src_adr, src_dat, dst_adr, dst_dat;
    logic        src_cyc, src_stb, src_ack;
    logic [3:0]  dst_sel;
    logic        dst_cyc, dst_stb, dst_we, dst_ack;
    logic        write_lock, cpu_rst, busy, done, error;

    logic [31:0] src_mem [4];
    logic [31:0] dst_mem [4];
    int          src_delay;
    logic        hang_en;
    logic [31:0] hang_adr;
    int          wait_cnt;
    logic        dst_clr;
    int          viol;
    logic        prev_src_ack, prev_dst_ack;

    int n_checks = 0;
    int n_fail   = 0;

    monitor_loader #(
        .SRC_BASE(SRC_BASE),
        .DST_BASE(DST_BASE),
        .WORDS   (4),
        .TIMEOUT (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .src_adr_o (src_adr),
        .src_dat_i (src_dat),
        .src_cyc_o (src_cyc),
        .src_stb_o (src_stb),
        .src_ack_i (src_ack),
        .dst_adr_o (dst_adr),
        .dst_dat_o (dst_dat),
        .dst_sel_o (dst_sel),
        .dst_cyc_o (dst_cyc),
        .dst_stb_o (dst_stb),
        .dst_we_o  (dst_we),
        .dst_ack_i (dst_ack),
        .write_lock(write_lock),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 sys_clk = ~sys_clk;

    // Flash slave: acks src_delay cycles after strobe, or never at hang_adr.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            src_ack  <= 1'b0;
            src_dat  <= '0;
            wait_cnt <= 0;
        end else begin
            src_ack <= 1'b0;
            if (src_cyc && src_stb && !src_ack) begin
                if (!(hang_en && src_adr == hang_adr) && wait_cnt >= src_delay - 1) begin
                    src_ack  <= 1'b1;
                    src_dat  <= src_mem[src_adr[3:2]];
                    wait_cnt <= 0;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                wait_cnt <= 0;
            end
        end
    end

    // Monitor RAM slave: acks one cycle after strobe, ignores a held strobe while ack is high.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dst_ack <= 1'b0;
        end else begin
            dst_ack <= 1'b0;
            if (dst_clr) begin
                for (int i = 0; i < 4; i++) dst_mem[i] <= '0;
            end else if (dst_cyc && dst_stb && !dst_ack) begin
                dst_ack <= 1'b1;
                if (dst_we) dst_mem[dst_adr[3:2]] <= dst_dat;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (prev_src_ack && src_stb) viol = viol + 1;
            if (prev_dst_ack && dst_stb) viol = viol + 1;
            if (dst_stb && (dst_we !== 1'b1 || dst_sel !== 4'hF)) viol = viol + 1;
            if (dst_stb && dst_adr[31:4] !== DST_BASE[31:4]) viol = viol + 1;
        end
        prev_src_ack = src_ack;
        prev_dst_ack = dst_ack;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_dst();
        dst_clr = 1'b1;
        @(negedge sys_clk);
        dst_clr = 1'b0;
    endtask

    task automatic run_copy(input int extra_start, output int done_cyc, output int err_cyc,
                            output int lock_rise, output int rst_fall);
        done_cyc  = -1;
        err_cyc   = -1;
        lock_rise = -1;
        rst_fall  = -1;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (lock_rise < 0 && write_lock) lock_rise = c;
            if (rst_fall < 0 && !cpu_rst) rst_fall = c;
            if (done) begin done_cyc = c; break; end
            if (error) begin err_cyc = c; break; end
            start = (c == extra_start);
            @(negedge sys_clk);
        end
        start = 1'b0;
    endtask

    task automatic check_data(input string tag);
        check({tag, "_w0"}, dst_mem[0], 32'h1111_1111);
        check({tag, "_w1"}, dst_mem[1], 32'h2222_2222);
        check({tag, "_w2"}, dst_mem[2], 32'h3333_3333);
        check({tag, "_w3"}, dst_mem[3], 32'h4444_4444);
    endtask

    int dc, ec, lr, rf;

    initial begin
        sys_rst_n = 1'b0;
        start     = 1'b0;
        src_delay = 1;
        hang_en   = 1'b0;
        hang_adr  = 32'h0000_0000;
        dst_clr   = 1'b0;
        viol      = 0;
        prev_src_ack = 1'b0;
        prev_dst_ack = 1'b0;
        // Word k lives at SRC_BASE+4k, which wraps through zero; index by address bits [3:2].
        src_mem[2] = 32'h1111_1111;
        src_mem[3] = 32'h2222_2222;
        src_mem[0] = 32'h3333_3333;
        src_mem[1] = 32'h4444_4444;
        repeat (3) @(negedge sys_clk);

        check("rst_write_lock", 32'(write_lock), 32'd1);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_src_adr", src_adr, 32'hFFFF_FFF8);
        check("rst_dst_adr", dst_adr, 32'h0002_0000);
        check("rst_dst_dat", dst_dat, 32'h0);
        check("rst_strobes", {28'd0, src_cyc, src_stb, dst_cyc, dst_stb}, 32'h0);
        check("rst_dst_we", 32'(dst_we), 32'd0);

        sys_rst_n = 1'b1;
        clear_dst();

        // Normal copy
        run_copy(0, dc, ec, lr, rf);
        check("norm_done_cyc", 32'(dc), 32'd17);
        check("norm_err_cyc", 32'(ec), 32'hFFFF_FFFF);
        check("norm_lock_rise", 32'(lr), 32'd17);
        check("norm_cpu_rst_fall", 32'(rf), 32'd17);
        check_data("norm");
        check("norm_busy", 32'(busy), 32'd0);

        // Wait states plus a start pulse while busy
        clear_dst();
        src_delay = 5;
        run_copy(10, dc, ec, lr, rf);
        check("wait_done_cyc", 32'(dc), 32'd33);
        check("wait_err_cyc", 32'(ec), 32'hFFFF_FFFF);
        check("wait_error", 32'(error), 32'd0);
        check_data("wait");

        // Timeout on word 2 (source address wraps to zero)
        clear_dst();
        src_delay = 1;
        hang_en   = 1'b1;
        run_copy(0, dc, ec, lr, rf);
        check("to_err_cyc", 32'(ec), 32'd18);
        check("to_done_cyc", 32'(dc), 32'hFFFF_FFFF);
        check("to_lock_rise", 32'(lr), 32'd18);
        check("to_cpu_rst", 32'(cpu_rst), 32'd1);
        check("to_write_lock", 32'(write_lock), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_src_cyc_stb", {30'd0, src_cyc, src_stb}, 32'h0);
        check("to_src_adr_cnt2", src_adr, 32'h0000_0000);
        repeat (3) @(negedge sys_clk);
        check("to_error_sticky", 32'(error), 32'd1);
        check("to_cnt_frozen", dst_adr, 32'h0002_0008);

        // Restart from ERROR with a healthy source
        hang_en = 1'b0;
        clear_dst();
        run_copy(0, dc, ec, lr, rf);
        check("rs_done_cyc", 32'(dc), 32'd17);
        check("rs_err_cyc", 32'(ec), 32'hFFFF_FFFF);
        check("rs_error", 32'(error), 32'd0);
        check_data("rs");

        // Reset during the write of word 1
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (6) @(negedge sys_clk);
        check("mid_in_write", {30'd0, dst_stb, write_lock}, 32'h2);
        check("mid_dst_adr", dst_adr, 32'h0002_0004);
        sys_rst_n = 1'b0;
        #1;
        check("mid_write_lock", 32'(write_lock), 32'd1);
        check("mid_cpu_rst", 32'(cpu_rst), 32'd1);
        check("mid_busy_done_err", {29'd0, busy, done, error}, 32'h0);
        check("mid_strobes", {27'd0, src_cyc, src_stb, dst_cyc, dst_stb, dst_we}, 32'h0);
        check("mid_dst_dat", dst_dat, 32'h0);
        check("mid_src_adr", src_adr, 32'hFFFF_FFF8);
        check("mid_dst_adr_rst", dst_adr, 32'h0002_0000);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        check("protocol_violations", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
